// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage (with helper module alu)
// Brief    : LoongArch execute stage: ID->EX register, ALU, multiplier,
//            radix-2 restoring divider and data-SRAM request generation.
// Revision : 1.0 - initial release
// ============================================================================

module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    // One-hot opcode: add sub slt sltu and nor or xor sll srl sra lui
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_slt;
    logic        w_sltu;
    logic [31:0] w_sra;

    assign w_sum  = alu_src1 + alu_src2;
    assign w_diff = alu_src1 - alu_src2;
    assign w_slt  = $signed(alu_src1) < $signed(alu_src2);
    assign w_sltu = alu_src1 < alu_src2;
    assign w_sra  = $signed(alu_src1) >>> alu_src2[4:0];

    assign alu_result = ({32{alu_op[0]}}  & w_sum)
                      | ({32{alu_op[1]}}  & w_diff)
                      | ({32{alu_op[2]}}  & {31'b0, w_slt})
                      | ({32{alu_op[3]}}  & {31'b0, w_sltu})
                      | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                      | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
                      | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
                      | ({32{alu_op[10]}} & w_sra)
                      | ({32{alu_op[11]}} & alu_src2);
endmodule

module ex_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ID_valid,
    input  logic         ID_ready_go,
    output logic         EX_allow_in,
    input  logic [11:0]  id_alu_op,
    input  logic [31:0]  id_src1,
    input  logic [31:0]  id_src2,
    input  logic [31:0]  id_rkd_value,
    input  logic [6:0]   id_md_op,
    input  logic [4:0]   id_ld_ctrl,
    input  logic [2:0]   id_st_ctrl,
    input  logic         id_rf_we,
    input  logic         id_res_from_mem,
    input  logic [4:0]   id_rf_waddr,
    input  logic [31:0]  id_pc,
    input  logic         MEM_allow_in,
    output logic         EX_ready_go,
    output logic         EXreg_valid,
    output logic [140:0] EXreg_bus,
    output logic [38:0]  EX_bypass_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        r_valid;
    logic [11:0] r_alu_op;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [31:0] r_rkd_value;
    logic [6:0]  r_md_op;
    logic [4:0]  r_ld_ctrl;
    logic [2:0]  r_st_ctrl;
    logic        r_rf_we;
    logic        r_res_from_mem;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_pc;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_dvd;
    logic [31:0] r_divisor;
    logic [31:0] r_rem;
    logic [31:0] r_quo;

    logic        w_in_fire;
    logic [31:0] w_alu_result;
    logic        w_div_op;
    logic        w_div_signed;
    logic        w_src1_neg;
    logic        w_src2_neg;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_ge;
    logic        w_div_zero;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_mul_signed;
    logic [32:0] w_m1;
    logic [32:0] w_m2;
    logic [63:0] w_product;
    logic [31:0] w_mul_result;
    logic        w_mul;
    logic [31:0] w_ex_result;
    logic        w_mem_op;

    assign w_in_fire   = ID_valid & ID_ready_go;
    assign EX_allow_in = ~r_valid | (EX_ready_go & MEM_allow_in);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid        <= 1'b0;
            r_alu_op       <= '0;
            r_src1         <= '0;
            r_src2         <= '0;
            r_rkd_value    <= '0;
            r_md_op        <= '0;
            r_ld_ctrl      <= '0;
            r_st_ctrl      <= '0;
            r_rf_we        <= 1'b0;
            r_res_from_mem <= 1'b0;
            r_rf_waddr     <= '0;
            r_pc           <= '0;
        end else if (EX_allow_in) begin
            r_valid <= w_in_fire;
            if (w_in_fire) begin
                r_alu_op       <= id_alu_op;
                r_src1         <= id_src1;
                r_src2         <= id_src2;
                r_rkd_value    <= id_rkd_value;
                r_md_op        <= id_md_op;
                r_ld_ctrl      <= id_ld_ctrl;
                r_st_ctrl      <= id_st_ctrl;
                r_rf_we        <= id_rf_we;
                r_res_from_mem <= id_res_from_mem;
                r_rf_waddr     <= id_rf_waddr;
                r_pc           <= id_pc;
            end
        end
    end

    alu u_alu (
        .alu_op     (r_alu_op),
        .alu_src1   (r_src1),
        .alu_src2   (r_src2),
        .alu_result (w_alu_result)
    );

    // Multiplier: 33-bit extension lets one signed multiply serve all three ops
    assign w_mul_signed = ~r_md_op[4];
    assign w_m1         = {w_mul_signed & r_src1[31], r_src1};
    assign w_m2         = {w_mul_signed & r_src2[31], r_src2};
    assign w_product    = $signed(w_m1) * $signed(w_m2);
    assign w_mul_result = r_md_op[6] ? w_product[31:0] : w_product[63:32];
    assign w_mul        = |r_md_op[6:4];

    assign w_div_op     = |r_md_op[3:0];
    assign w_div_signed = r_md_op[3] | r_md_op[1];
    assign w_src1_neg   = w_div_signed & r_src1[31];
    assign w_src2_neg   = w_div_signed & r_src2[31];
    assign w_abs1       = w_src1_neg ? (32'd0 - r_src1) : r_src1;
    assign w_abs2       = w_src2_neg ? (32'd0 - r_src2) : r_src2;

    // Restoring step: shift in next dividend bit, subtract if it fits
    assign w_shift = {r_rem, r_dvd[31]};
    assign w_trial = w_shift - {1'b0, r_divisor};
    assign w_ge    = ~w_trial[32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_valid & w_div_op) begin
                        r_state   <= S_BUSY;
                        r_cnt     <= '0;
                        r_dvd     <= w_abs1;
                        r_divisor <= w_abs2;
                        r_rem     <= '0;
                        r_quo     <= '0;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_ge ? w_trial[31:0] : w_shift[31:0];
                    r_dvd <= {r_dvd[30:0], 1'b0};
                    r_quo <= {r_quo[30:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (EX_ready_go & MEM_allow_in) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sign fix-up reads the held operands, so the result is stable in DONE
    assign w_div_zero = (r_src2 == 32'd0);
    assign w_quo_fix  = w_div_zero ? 32'hFFFF_FFFF :
                        (w_src1_neg ^ w_src2_neg) ? (32'd0 - r_quo) : r_quo;
    assign w_rem_fix  = w_div_zero ? r_src1 :
                        w_src1_neg ? (32'd0 - r_rem) : r_rem;

    assign EX_ready_go = ~w_div_op | (r_state == S_DONE);
    assign w_ex_result = (r_md_op[3] | r_md_op[2]) ? w_quo_fix :
                         (r_md_op[1] | r_md_op[0]) ? w_rem_fix : w_alu_result;

    assign w_mem_op       = (|r_ld_ctrl) | (|r_st_ctrl);
    assign data_sram_en   = r_valid & EX_ready_go & MEM_allow_in & w_mem_op;
    assign data_sram_addr = w_alu_result;

    always_comb begin
        data_sram_we    = 4'b0000;
        data_sram_wdata = r_rkd_value;
        if (r_st_ctrl[1]) begin
            data_sram_wdata = {2{r_rkd_value[15:0]}};
        end else if (r_st_ctrl[0]) begin
            data_sram_wdata = {4{r_rkd_value[7:0]}};
        end
        if (data_sram_en) begin
            if (r_st_ctrl[2]) begin
                data_sram_we = 4'b1111;
            end else if (r_st_ctrl[1]) begin
                data_sram_we = w_alu_result[1] ? 4'b1100 : 4'b0011;
            end else if (r_st_ctrl[0]) begin
                data_sram_we = 4'b0001 << w_alu_result[1:0];
            end
        end
    end

    assign EXreg_valid   = r_valid;
    assign EXreg_bus     = {w_mul, w_mul_result, w_ex_result, r_rkd_value, r_ld_ctrl,
                            r_rf_we, r_res_from_mem, r_rf_waddr, r_pc};
    assign EX_bypass_bus = {r_rf_waddr, r_rf_we & r_valid, r_res_from_mem & r_valid,
                            w_ex_result};
endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Directed self-checking bench for ex_stage.
// Revision : 1.0 - initial release
// ============================================================================

module tb_ex_stage;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         ID_valid = 1'b0;
    logic         ID_ready_go = 1'b0;
    logic         EX_allow_in;
    logic [11:0]  id_alu_op = '0;
    logic [31:0]  id_src1 = '0;
    logic [31:0]  id_src2 = '0;
    logic [31:0]  id_rkd_value = '0;
    logic [6:0]   id_md_op = '0;
    logic [4:0]   id_ld_ctrl = '0;
    logic [2:0]   id_st_ctrl = '0;
    logic         id_rf_we = 1'b0;
    logic         id_res_from_mem = 1'b0;
    logic [4:0]   id_rf_waddr = '0;
    logic [31:0]  id_pc = '0;
    logic         MEM_allow_in = 1'b1;
    logic         EX_ready_go;
    logic         EXreg_valid;
    logic [140:0] EXreg_bus;
    logic [38:0]  EX_bypass_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int checks = 0;
    int failures = 0;

    localparam logic [11:0] c_op_add = 12'h001;
    localparam logic [6:0]  c_mul_w   = 7'b1000000;
    localparam logic [6:0]  c_mulh_wu = 7'b0010000;
    localparam logic [6:0]  c_div_w   = 7'b0001000;
    localparam logic [6:0]  c_div_wu  = 7'b0000100;
    localparam logic [6:0]  c_mod_w   = 7'b0000010;
    localparam logic [6:0]  c_mod_wu  = 7'b0000001;

    ex_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ID_valid        (ID_valid),
        .ID_ready_go     (ID_ready_go),
        .EX_allow_in     (EX_allow_in),
        .id_alu_op       (id_alu_op),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_rkd_value    (id_rkd_value),
        .id_md_op        (id_md_op),
        .id_ld_ctrl      (id_ld_ctrl),
        .id_st_ctrl      (id_st_ctrl),
        .id_rf_we        (id_rf_we),
        .id_res_from_mem (id_res_from_mem),
        .id_rf_waddr     (id_rf_waddr),
        .id_pc           (id_pc),
        .MEM_allow_in    (MEM_allow_in),
        .EX_ready_go     (EX_ready_go),
        .EXreg_valid     (EXreg_valid),
        .EXreg_bus       (EXreg_bus),
        .EX_bypass_bus   (EX_bypass_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for exactly one edge; caller ensures EX_allow_in
    task automatic issue(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] rkd, input logic [6:0] md, input logic [2:0] st);
        id_alu_op    = op;
        id_src1      = s1;
        id_src2      = s2;
        id_rkd_value = rkd;
        id_md_op     = md;
        id_st_ctrl   = st;
        id_ld_ctrl   = 5'b0;
        id_rf_we     = 1'b1;
        id_rf_waddr  = 5'd3;
        id_pc        = 32'h1c00_0100;
        ID_valid     = 1'b1;
        ID_ready_go  = 1'b1;
        step();
        ID_valid     = 1'b0;
        #1;
    endtask

    task automatic run_div(input string tag, input logic [6:0] md, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int n;
        issue(12'h000, a, b, 32'h0, md, 3'b000);
        n = 0;
        while (!EX_ready_go && n < 100) begin
            step();
            n++;
        end
        check($sformatf("%s_latency", tag), 64'(n), 64'd33);
        check(tag, {32'b0, EX_bypass_bus[31:0]}, {32'b0, exp});
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_valid", {63'b0, EXreg_valid}, 64'd0);
        check("rst_ready_go", {63'b0, EX_ready_go}, 64'd1);
        check("rst_allow_in", {63'b0, EX_allow_in}, 64'd1);
        check("rst_sram_en", {63'b0, data_sram_en}, 64'd0);
        check("rst_sram_we", {60'b0, data_sram_we}, 64'd0);
        check("rst_bypass_bits", {62'b0, EX_bypass_bus[33:32]}, 64'd0);
        #10;
        resetn = 1'b1;
        step();

        // add.w 5 + 7
        issue(c_op_add, 32'd5, 32'd7, 32'd0, 7'b0, 3'b000);
        check("add_valid", {63'b0, EXreg_valid}, 64'd1);
        check("add_result", {32'b0, EX_bypass_bus[31:0]}, 64'd12);
        check("add_ready_go", {63'b0, EX_ready_go}, 64'd1);
        check("add_sram_en", {63'b0, data_sram_en}, 64'd0);
        check("add_bypass_we", {63'b0, EX_bypass_bus[33]}, 64'd1);
        step();
        check("add_occupancy", {63'b0, EXreg_valid}, 64'd0);
        check("bubble_bypass_we", {63'b0, EX_bypass_bus[33]}, 64'd0);

        // Divides, issued back-to-back
        run_div("div_w_neg", c_div_w, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("mod_w_neg", c_mod_w, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("div_wu_zero", c_div_wu, 32'd10, 32'd0, 32'hFFFF_FFFF);
        run_div("mod_wu_zero", c_mod_wu, 32'd10, 32'd0, 32'd10);
        run_div("div_w_ovf", c_div_w, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        step();
        check("div_drained", {63'b0, EXreg_valid}, 64'd0);

        // st_b to 0x1003 with a 3-cycle MEM stall
        issue(c_op_add, 32'h0000_1000, 32'd3, 32'h0000_00AB, 7'b0, 3'b001);
        MEM_allow_in = 1'b0;
        #1;
        check("stb_stall0_en", {63'b0, data_sram_en}, 64'd0);
        step();
        check("stb_stall1_en", {63'b0, data_sram_en}, 64'd0);
        step();
        check("stb_stall2_en", {63'b0, data_sram_en}, 64'd0);
        check("stb_stall2_we", {60'b0, data_sram_we}, 64'd0);
        step();
        MEM_allow_in = 1'b1;
        #1;
        check("stb_en", {63'b0, data_sram_en}, 64'd1);
        check("stb_we", {60'b0, data_sram_we}, 64'h8);
        check("stb_wdata", {32'b0, data_sram_wdata}, 64'hABAB_ABAB);
        check("stb_addr", {32'b0, data_sram_addr}, 64'h1003);
        step();
        check("stb_once", {63'b0, data_sram_en}, 64'd0);

        // Multiplies
        issue(12'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, c_mulh_wu, 3'b000);
        check("mulh_wu_flag", {63'b0, EXreg_bus[140]}, 64'd1);
        check("mulh_wu_result", {32'b0, EXreg_bus[139:108]}, 64'hFFFF_FFFE);
        issue(12'h000, 32'd3, 32'hFFFF_FFFC, 32'd0, c_mul_w, 3'b000);
        check("mul_w_result", {32'b0, EXreg_bus[139:108]}, 64'hFFFF_FFF4);
        step();

        // Reset in the middle of a divide
        issue(12'h000, 32'd100, 32'd3, 32'd0, c_div_w, 3'b000);
        repeat (11) step();
        check("middiv_busy", {63'b0, EX_ready_go}, 64'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("middiv_rst_valid", {63'b0, EXreg_valid}, 64'd0);
        check("middiv_rst_ready_go", {63'b0, EX_ready_go}, 64'd1);
        check("middiv_rst_allow_in", {63'b0, EX_allow_in}, 64'd1);
        resetn = 1'b1;
        step();
        issue(c_op_add, 32'd5, 32'd7, 32'd0, 7'b0, 3'b000);
        check("post_rst_add", {32'b0, EX_bypass_bus[31:0]}, 64'd12);
        check("post_rst_ready_go", {63'b0, EX_ready_go}, 64'd1);
        step();
        check("post_rst_occupancy", {63'b0, EXreg_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
